alu_op_issuer: RTL and testbench

Command-side sequencer that drives the ArithmeticLogicUnit and collects its results. It accepts one operation at a time from a host over a valid/ready command channel. It holds `op`/`X`/`Y` stable toward the ALU and waits for the completion flag that matches the operation class. It then captures `result`/`remainder` and returns them on a valid/ready response channel with a status code. It is the initiator end of the ALU's op/suff interface and sits between the control path and the ALU.

---
 rtl/alu_op_issuer.sv | 151 +++++++++++++++
 tb/tb_alu_op_issuer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Command-side sequencer for the ArithmeticLogicUnit: issues one op at a time, waits for
// the matching completion flag (or times out) and returns the captured result with a status.
module alu_op_issuer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [31:0] cmd_x,
  input  logic [31:0] cmd_y,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [3:0]  alu_suff,
  input  logic [66:0] alu_result,
  input  logic [32:0] alu_remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [66:0] rsp_result,
  output logic [32:0] rsp_remainder,
  output logic [1:0]  rsp_status
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_DIVZERO = 2'b11;

  // S_REJECT holds rejected commands one cycle so their response lands one cycle after accept
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_REJECT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [31:0]   x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [66:0]   res_q, res_d;
  logic [32:0]   rem_q, rem_d;
  logic [1:0]    status_q, status_d;
  logic [1:0]    cls;
  logic          cmd_legal;

  always_comb begin
    case (op_q)
      5'd1, 5'd2: cls = 2'd0;
      5'd3:       cls = 2'd1;
      5'd4:       cls = 2'd2;
      default:    cls = 2'd3;
    endcase
  end

  assign cmd_legal = (cmd_op >= 5'd1) && (cmd_op <= 5'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      rem_q    <= '0;
      status_q <= ST_OK;
    end else begin
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      rem_q    <= rem_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    rem_d    = rem_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          x_d   = cmd_x;
          y_d   = cmd_y;
          res_d = '0;
          rem_d = '0;
          if (!cmd_legal) begin
            status_d = ST_ILLEGAL;
            state_d  = S_REJECT;
          end else if (cmd_op == 5'd4 && cmd_y == '0) begin
            status_d = ST_DIVZERO;
            state_d  = S_REJECT;
          end else begin
            status_d = ST_OK;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_suff[cls]) begin
          res_d    = alu_result;
          rem_d    = (op_q == 5'd4) ? alu_remainder : '0;
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d    = CW'(TIMEOUT);
          res_d    = '0;
          rem_d    = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REJECT: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    alu_op    = (state_q == S_ISSUE || state_q == S_WAIT) ? op_q : '0;
  end

  assign alu_x         = x_q;
  assign alu_y         = y_q;
  assign rsp_result    = res_q;
  assign rsp_remainder = rem_q;
  assign rsp_status    = status_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed + randomized bench for alu_op_issuer with a behavioural ALU/host model.
module tb_alu_op_issuer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [31:0] cmd_x, cmd_y;
  logic [4:0]  alu_op;
  logic [31:0] alu_x, alu_y;
  logic [3:0]  alu_suff;
  logic [66:0] alu_result;
  logic [32:0] alu_remainder;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [66:0] rsp_result;
  logic [32:0] rsp_remainder;
  logic [1:0]  rsp_status;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_suff(alu_suff), .alu_result(alu_result), .alu_remainder(alu_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_remainder(rsp_remainder), .rsp_status(rsp_status)
  );

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [66:0] rnd67();
    logic [66:0] r;
    r = {3'($urandom()), $urandom(), $urandom()};
    return r;
  endfunction

  // What a correct ALU would return for a legal op
  function automatic logic [66:0] ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [66:0] a, b;
    a = {35'd0, x};
    b = {35'd0, y};
    case (op)
      5'd1: return a + b;
      5'd2: return a - b;
      5'd3: return a * b;
      5'd4: return (y == 0) ? 67'd0 : a / b;
      5'd5: return a >> y[4:0];
      5'd6: return a << y[4:0];
      5'd7: return a & b;
      5'd8: return a | b;
      5'd9: return a ^ b;
      default: return 67'd0;
    endcase
  endfunction

  // One full transaction. flag_at: WAIT cycle (1..TO) in which the matching flag rises, 0 = never.
  task automatic do_cmd(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int flag_at, input int bp, input bit early_ready);
    bit          legal, dz, done;
    int          k;
    logic [3:0]  kmask;
    logic [66:0] er;
    logic [32:0] erm;
    logic [1:0]  es;

    legal = (op >= 1) && (op <= 9);
    dz    = legal && (op == 4) && (y == 0);
    k     = (op <= 2) ? 0 : (op == 3) ? 1 : (op == 4) ? 2 : 3;
    kmask = 4'(1 << k);
    if (!legal)                          es = 2'b01;
    else if (dz)                         es = 2'b11;
    else if (flag_at >= 1 && flag_at <= TO) es = 2'b00;
    else                                 es = 2'b10;
    er  = (es == 2'b00) ? ref_alu(op, x, y) : 67'd0;
    erm = (es == 2'b00 && op == 4) ? {1'b0, x % y} : 33'd0;

    check("cmd_ready_idle", {66'd0, cmd_ready}, 67'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
    if (early_ready) rsp_ready = 1'b1;
    @(posedge clk); #1;
    // keep presenting a different command: it must be ignored while busy
    cmd_op = 5'($urandom_range(1, 9)); cmd_x = $urandom(); cmd_y = $urandom();
    check("cmd_ready_busy", {66'd0, cmd_ready}, 67'd0);

    if (!legal || dz) begin
      check("rej_alu_op", {62'd0, alu_op}, 67'd0);
      check("rej_no_rsp_yet", {66'd0, rsp_valid}, 67'd0);
      @(posedge clk); #1;
    end else begin
      check("issue_alu_op", {62'd0, alu_op}, {62'd0, op});
      check("issue_alu_x", {35'd0, alu_x}, {35'd0, x});
      check("issue_alu_y", {35'd0, alu_y}, {35'd0, y});
      check("issue_no_rsp", {66'd0, rsp_valid}, 67'd0);
      alu_suff = 4'hF; alu_result = rnd67(); alu_remainder = 33'($urandom());
      @(posedge clk); #1;
      done = 1'b0;
      for (int c = 1; c <= TO && !done; c++) begin
        if (c == flag_at) begin
          alu_suff      = kmask | (4'($urandom()) & ~kmask);
          alu_result    = ref_alu(op, x, y);
          alu_remainder = (op == 4) ? {1'b0, x % y} : {1'b1, $urandom()};
        end else begin
          alu_suff      = 4'($urandom()) & ~kmask;
          alu_result    = rnd67();
          alu_remainder = 33'($urandom());
        end
        check("wait_alu_op", {62'd0, alu_op}, {62'd0, op});
        check("wait_alu_x", {35'd0, alu_x}, {35'd0, x});
        @(posedge clk); #1;
        if (c == flag_at || c == TO) done = 1'b1;
        else check("wait_no_rsp", {66'd0, rsp_valid}, 67'd0);
      end
      alu_suff = 4'h0;
    end
    cmd_valid = 1'b0;

    check("rsp_valid", {66'd0, rsp_valid}, 67'd1);
    check("rsp_status", {65'd0, rsp_status}, {65'd0, es});
    check("rsp_result", rsp_result, er);
    check("rsp_remainder", {34'd0, rsp_remainder}, {34'd0, erm});
    check("rsp_alu_op", {62'd0, alu_op}, 67'd0);
    check("rsp_cmd_ready", {66'd0, cmd_ready}, 67'd0);

    if (!early_ready) begin
      repeat (bp) begin
        alu_suff = 4'($urandom()); alu_result = rnd67(); alu_remainder = 33'($urandom());
        @(posedge clk); #1;
        check("bp_valid", {66'd0, rsp_valid}, 67'd1);
        check("bp_result", rsp_result, er);
        check("bp_status", {65'd0, rsp_status}, {65'd0, es});
        check("bp_cmd_ready", {66'd0, cmd_ready}, 67'd0);
      end
      alu_suff = 4'h0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", {66'd0, rsp_valid}, 67'd0);
    check("post_cmd_ready", {66'd0, cmd_ready}, 67'd1);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] rx, ry;
    int          sel, fa, rbp;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    alu_suff = '0; alu_result = '0; alu_remainder = '0; rsp_ready = 1'b0;
    #2;
    check("rst_cmd_ready", {66'd0, cmd_ready}, 67'd1);
    check("rst_alu_op", {62'd0, alu_op}, 67'd0);
    check("rst_alu_x", {35'd0, alu_x}, 67'd0);
    check("rst_alu_y", {35'd0, alu_y}, 67'd0);
    check("rst_rsp_valid", {66'd0, rsp_valid}, 67'd0);
    check("rst_rsp_result", rsp_result, 67'd0);
    check("rst_rsp_rem", {34'd0, rsp_remainder}, 67'd0);
    check("rst_rsp_status", {65'd0, rsp_status}, 67'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(5'd1, 32'd5, 32'd7, 1, 0, 1'b0);        // add, first-sample flag
    do_cmd(5'd4, 32'd100, 32'd7, 33, 0, 1'b0);     // div, late flag
    do_cmd(5'd3, $urandom(), $urandom(), 0, 0, 1'b0); // mul never flagged -> timeout
    do_cmd(5'd12, $urandom(), $urandom(), 0, 0, 1'b0);
    do_cmd(5'd0, $urandom(), $urandom(), 0, 0, 1'b0);
    do_cmd(5'd4, $urandom(), 32'd0, 1, 0, 1'b0);   // divide by zero
    do_cmd(5'd7, $urandom(), $urandom(), TO, 0, 1'b0); // flag on the timeout edge wins
    do_cmd(5'd9, $urandom(), $urandom(), TO - 1, 0, 1'b1);
    do_cmd(5'd2, $urandom(), $urandom(), 2, 10, 1'b0); // 10-cycle backpressure

    for (int i = 0; i < 10; i++) begin
      rop = 5'($urandom_range(0, 15));
      rx  = $urandom();
      ry  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      sel = $urandom_range(0, 3);
      fa  = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? TO : $urandom_range(1, TO);
      rbp = $urandom_range(0, 3);
      do_cmd(rop, rx, ry, fa, rbp, (rbp == 0) && ($urandom_range(0, 1) == 1));
    end

    // reset while an op is in flight
    cmd_valid = 1'b1; cmd_op = 5'd1; cmd_x = 32'd9; cmd_y = 32'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midwait_alu_op", {62'd0, alu_op}, 67'd1);
    rst_n = 1'b0;
    #1;
    check("arst_alu_op", {62'd0, alu_op}, 67'd0);
    check("arst_alu_x", {35'd0, alu_x}, 67'd0);
    check("arst_cmd_ready", {66'd0, cmd_ready}, 67'd1);
    check("arst_rsp_valid", {66'd0, rsp_valid}, 67'd0);
    #2 rst_n = 1'b1;
    alu_suff = 4'hF; alu_result = 67'd13;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", {66'd0, rsp_valid}, 67'd0);
      check("post_rst_alu_op", {62'd0, alu_op}, 67'd0);
    end
    alu_suff = 4'h0; rsp_ready = 1'b0;
    do_cmd(5'd8, $urandom(), $urandom(), 3, 1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
